// File: rtl/led_framebuffer_if.sv
// led_framebuffer_if: pixel-producer write port, swap handshake, frame_end from
// led_driver and the row-pair read port of the double-buffered frame store.
interface led_framebuffer_if #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int RW = $clog2(HEIGHT / 2);

  // Producer side
  logic          wr_en;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [2:0]    wr_rgb;
  logic          wr_ready;
  logic          swap_req;
  logic          swap_done;

  // led_driver side
  logic          frame_end;
  logic          rd_en;
  logic [XW-1:0] rd_x;
  logic [RW-1:0] rd_row;
  logic [2:0]    rd_rgb0;
  logic [2:0]    rd_rgb1;
  logic          rd_valid;
  logic          front_sel;

  modport slave (
    input  wr_en, wr_x, wr_y, wr_rgb, swap_req, frame_end, rd_en, rd_x, rd_row,
    output wr_ready, swap_done, rd_rgb0, rd_rgb1, rd_valid, front_sel
  );

  modport master (
    output wr_en, wr_x, wr_y, wr_rgb, swap_req, frame_end, rd_en, rd_x, rd_row,
    input  wr_ready, swap_done, rd_rgb0, rd_rgb1, rd_valid, front_sel
  );
endinterface

// File: rtl/led_framebuffer.sv
// led_framebuffer: double-buffered WIDTH x HEIGHT 1-bit RGB frame store.
// The producer draws into the back buffer; led_driver scans row pairs out of
// the front buffer. A requested swap is held until the panel signals the end
// of a frame, so a half-drawn picture is never shown. Optionally the new back
// buffer is zero-filled after every swap, one address per cycle.
// Each buffer is split into a top and bottom half so that one address
// {row, x} yields both pixels of a scan row pair in a single read.
// WIDTH and HEIGHT are expected to be powers of two.
module led_framebuffer #(
  parameter int WIDTH         = 64,
  parameter int HEIGHT        = 64,
  parameter int CLEAR_ON_SWAP = 1
) (
  input logic              clk,
  input logic              reset,
  led_framebuffer_if.slave fb
);
  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int HALF  = HEIGHT / 2;
  localparam int RW    = $clog2(HALF);
  localparam int AW    = XW + RW;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  state_t state, next_state;

  logic          front_sel_q;
  logic          wr_ready_q;
  logic          swap_done_q;
  logic          rd_valid_q;
  logic [2:0]    rd_rgb0_q;
  logic [2:0]    rd_rgb1_q;
  logic [AW-1:0] clr_cnt;

  // Four half-frame arrays: top/bottom half of buffer 0 and buffer 1.
  // Contents are never reset; they are sized as plain block RAMs.
  logic [2:0] top0 [DEPTH];
  logic [2:0] top1 [DEPTH];
  logic [2:0] bot0 [DEPTH];
  logic [2:0] bot1 [DEPTH];

  logic          swap_accept;
  logic          swap_fire;
  logic          clr_last;
  logic          wr_fire;
  logic          wr_is_bot;
  logic [RW-1:0] wr_row;
  logic          we_top;
  logic          we_bot;
  logic          we_buf;
  logic [AW-1:0] waddr;
  logic [2:0]    wdata;
  logic [AW-1:0] raddr;

  // wr_ready is high exactly when the FSM sits in IDLE, so it gates both the
  // producer's writes and its swap requests.
  assign swap_accept = wr_ready_q && fb.swap_req;
  assign wr_fire     = wr_ready_q && fb.wr_en;
  assign swap_fire   = (state == PENDING) && fb.frame_end;
  assign clr_last    = &clr_cnt;

  // Rows in the lower half of the panel land in the bottom array, rebased to 0.
  assign wr_is_bot = int'(fb.wr_y) >= HALF;
  assign wr_row    = wr_is_bot ? RW'(fb.wr_y - YW'(HALF)) : RW'(fb.wr_y);
  assign raddr     = {fb.rd_row, fb.rd_x};

  // Next-state logic for the swap handshake and the post-swap clear sweep.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (swap_accept) next_state = PENDING;
      end
      PENDING: begin
        if (fb.frame_end) next_state = (CLEAR_ON_SWAP != 0) ? CLEAR : IDLE;
      end
      CLEAR: begin
        if (clr_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, buffer select, registered handshake outputs and the
  // clear address counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      front_sel_q <= 1'b0;
      wr_ready_q  <= 1'b1;
      swap_done_q <= 1'b0;
      clr_cnt     <= '0;
    end else begin
      state       <= next_state;
      wr_ready_q  <= (next_state == IDLE);
      swap_done_q <= swap_fire;
      if (swap_fire) front_sel_q <= ~front_sel_q;
      clr_cnt     <= (state == CLEAR) ? clr_cnt + AW'(1) : '0;
    end
  end

  // Back-buffer write port: the clear sweep owns it during CLEAR, otherwise
  // accepted producer writes go to the half selected by wr_y.
  always_comb begin
    we_top = 1'b0;
    we_bot = 1'b0;
    we_buf = ~front_sel_q;
    waddr  = {wr_row, fb.wr_x};
    wdata  = fb.wr_rgb;
    if (state == CLEAR) begin
      we_top = 1'b1;
      we_bot = 1'b1;
      waddr  = clr_cnt;
      wdata  = '0;
    end else if (wr_fire) begin
      we_top = ~wr_is_bot;
      we_bot = wr_is_bot;
    end
  end

  // Memory writes; only the back buffer is ever written.
  always_ff @(posedge clk) begin
    if (we_top && !we_buf) top0[waddr] <= wdata;
    if (we_top &&  we_buf) top1[waddr] <= wdata;
    if (we_bot && !we_buf) bot0[waddr] <= wdata;
    if (we_bot &&  we_buf) bot1[waddr] <= wdata;
  end

  // Registered row-pair read from the front buffer; data holds while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_rgb0_q  <= '0;
      rd_rgb1_q  <= '0;
    end else begin
      rd_valid_q <= fb.rd_en;
      if (fb.rd_en) begin
        rd_rgb0_q <= front_sel_q ? top1[raddr] : top0[raddr];
        rd_rgb1_q <= front_sel_q ? bot1[raddr] : bot0[raddr];
      end
    end
  end

  assign fb.wr_ready  = wr_ready_q;
  assign fb.swap_done = swap_done_q;
  assign fb.front_sel = front_sel_q;
  assign fb.rd_valid  = rd_valid_q;
  assign fb.rd_rgb0   = rd_rgb0_q;
  assign fb.rd_rgb1   = rd_rgb1_q;
endmodule

// File: tb/tb_led_framebuffer.sv
// tb_led_framebuffer: randomized and directed stimulus for led_framebuffer,
// checked every cycle against a picture-level model that keeps two full
// 64x64 frames, the displayed-frame index and the swap/clear progress.
module tb_led_framebuffer;
  localparam int W     = 64;
  localparam int H     = 64;
  localparam int HALF  = H / 2;
  localparam int DEPTH = W * HALF;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  led_framebuffer_if #(.WIDTH(W), .HEIGHT(H)) fb ();

  led_framebuffer #(.WIDTH(W), .HEIGHT(H), .CLEAR_ON_SWAP(1)) dut (
    .clk   (clk),
    .reset (reset),
    .fb    (fb)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: two whole frames indexed [buffer][y][x] plus handshake status.
  bit [2:0] frame [2][H][W];
  bit       m_front;
  bit       m_pending;
  bit       m_ready;
  bit       m_swap_done;
  bit       m_valid;
  bit [2:0] m_rgb0;
  bit [2:0] m_rgb1;
  int       m_clear_left;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic check_all();
    check_output("wr_ready", fb.wr_ready, m_ready);
    check_output("front_sel", fb.front_sel, m_front);
    check_output("swap_done", fb.swap_done, m_swap_done);
    check_output("rd_valid", fb.rd_valid, m_valid);
    check_output("rd_rgb0", fb.rd_rgb0, m_rgb0);
    check_output("rd_rgb1", fb.rd_rgb1, m_rgb1);
  endtask

  task automatic model_reset();
    m_front      = 1'b0;
    m_pending    = 1'b0;
    m_ready      = 1'b1;
    m_swap_done  = 1'b0;
    m_valid      = 1'b0;
    m_rgb0       = '0;
    m_rgb1       = '0;
    m_clear_left = 0;
  endtask

  task automatic clear_inputs();
    fb.wr_en     = 1'b0;
    fb.wr_x      = '0;
    fb.wr_y      = '0;
    fb.wr_rgb    = '0;
    fb.swap_req  = 1'b0;
    fb.frame_end = 1'b0;
    fb.rd_en     = 1'b0;
    fb.rd_x      = '0;
    fb.rd_row    = '0;
  endtask

  // Advance one clock with the inputs currently driven, update the model from
  // the frame-level rules, then compare all outputs 1 time unit after the edge.
  task automatic apply_stimulus();
    bit old_ready;
    int k;
    old_ready   = m_ready;
    m_swap_done = 1'b0;
    m_valid     = fb.rd_en;
    if (fb.rd_en) begin
      m_rgb0 = frame[m_front][fb.rd_row][fb.rd_x];
      m_rgb1 = frame[m_front][int'(fb.rd_row) + HALF][fb.rd_x];
    end
    if (old_ready && fb.wr_en) frame[!m_front][fb.wr_y][fb.wr_x] = fb.wr_rgb;
    if (m_clear_left > 0) begin
      k = DEPTH - m_clear_left;
      frame[!m_front][k / W][k % W]        = '0;
      frame[!m_front][k / W + HALF][k % W] = '0;
      m_clear_left--;
      if (m_clear_left == 0) m_ready = 1'b1;
    end else if (m_pending && fb.frame_end) begin
      m_front      = !m_front;
      m_swap_done  = 1'b1;
      m_pending    = 1'b0;
      m_clear_left = DEPTH;
    end else if (old_ready && fb.swap_req) begin
      m_pending = 1'b1;
      m_ready   = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic random_write();
    fb.wr_en  = 1'($urandom_range(1));
    fb.wr_x   = 6'($urandom_range(W - 1));
    fb.wr_y   = 6'($urandom_range(H - 1));
    fb.wr_rgb = 3'($urandom_range(7));
  endtask

  task automatic random_read();
    fb.rd_en  = 1'($urandom_range(1));
    fb.rd_x   = 6'($urandom_range(W - 1));
    fb.rd_row = 5'($urandom_range(HALF - 1));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (fb.wr_ready !== 1'b1 && n < 4000) begin
      n++;
      apply_stimulus();
    end
    check_output(tag, fb.wr_ready, 1'b1);
  endtask

  task automatic do_swap();
    wait_ready("swap_wait");
    fb.swap_req = 1'b1;
    apply_stimulus();
    fb.swap_req  = 1'b0;
    fb.frame_end = 1'b1;
    apply_stimulus();
    fb.frame_end = 1'b0;
    wait_ready("clear_wait");
  endtask

  task automatic read_pixel(input int x, input int row);
    fb.rd_en  = 1'b1;
    fb.rd_x   = 6'(x);
    fb.rd_row = 5'(row);
    apply_stimulus();
    fb.rd_en = 1'b0;
  endtask

  initial begin
    int cnt;
    bit f0;

    // Reset state
    reset = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Fill the whole back buffer, with the two directed pixels last
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        fb.wr_en  = 1'b1;
        fb.wr_x   = 6'(x);
        fb.wr_y   = 6'(y);
        fb.wr_rgb = 3'($urandom_range(7));
        apply_stimulus();
      end
    end
    fb.wr_x = 6'd5; fb.wr_y = 6'd3;  fb.wr_rgb = 3'b101; apply_stimulus();
    fb.wr_x = 6'd5; fb.wr_y = 6'd35; fb.wr_rgb = 3'b010; apply_stimulus();
    fb.wr_en = 1'b0;

    // Swap request held pending for 1000 cycles; writes and requests dropped
    fb.swap_req = 1'b1;
    apply_stimulus();
    fb.swap_req = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      random_write();
      fb.swap_req = 1'($urandom_range(1));
      apply_stimulus();
    end
    clear_inputs();
    check_output("pending_front", fb.front_sel, 1'b0);

    // frame_end publishes the buffer; count busy cycles from the swap
    fb.frame_end = 1'b1;
    apply_stimulus();
    fb.frame_end = 1'b0;
    check_output("swap_pulse", fb.swap_done, 1'b1);
    check_output("swap_front", fb.front_sel, 1'b1);
    cnt = 0;
    while (fb.wr_ready !== 1'b1 && cnt < 3000) begin
      cnt++;
      random_write();
      random_read();
      apply_stimulus();
    end
    clear_inputs();
    check_output("clear_len", cnt, DEPTH);

    // Directed row-pair read
    read_pixel(5, 3);
    check_output("dir_valid", fb.rd_valid, 1'b1);
    check_output("dir_rgb0", fb.rd_rgb0, 3'b101);
    check_output("dir_rgb1", fb.rd_rgb1, 3'b010);
    apply_stimulus();

    // Random traffic with occasional swaps and frame ends
    for (int i = 0; i < 6000; i++) begin
      random_write();
      random_read();
      fb.swap_req  = ($urandom_range(199) == 0);
      fb.frame_end = ($urandom_range(299) == 0);
      apply_stimulus();
    end
    clear_inputs();

    // swap_req together with frame_end in IDLE waits for the next frame_end
    wait_ready("idle_wait");
    f0 = fb.front_sel;
    fb.swap_req  = 1'b1;
    fb.frame_end = 1'b1;
    apply_stimulus();
    clear_inputs();
    for (int i = 0; i < 20; i++) begin
      fb.swap_req = (i == 5);
      apply_stimulus();
    end
    clear_inputs();
    check_output("no_early_swap", fb.front_sel, f0);
    fb.frame_end = 1'b1;
    apply_stimulus();
    fb.frame_end = 1'b0;
    check_output("late_swap", fb.front_sel, !f0);
    for (int i = 0; i < 10; i++) apply_stimulus();
    check_output("single_swap", fb.front_sel, !f0);
    wait_ready("after_late");

    // Scan the whole front buffer while hammering the back buffer
    for (int r = 0; r < HALF; r++) begin
      for (int x = 0; x < W; x++) begin
        random_write();
        fb.rd_en  = 1'b1;
        fb.rd_x   = 6'(x);
        fb.rd_row = 5'(r);
        apply_stimulus();
      end
    end
    clear_inputs();

    // A pixel comes back cleared after it has been through a clear sweep
    fb.wr_en = 1'b1; fb.wr_x = 6'd10; fb.wr_y = 6'd40; fb.wr_rgb = 3'b111;
    apply_stimulus();
    clear_inputs();
    do_swap();
    read_pixel(10, 8);
    check_output("shown_pixel", fb.rd_rgb1, 3'b111);
    do_swap();
    do_swap();
    read_pixel(10, 8);
    check_output("cleared_pixel", fb.rd_rgb1, 3'b000);

    // Asynchronous reset in the middle of a clear sweep
    wait_ready("pre_reset");
    fb.swap_req = 1'b1;
    apply_stimulus();
    fb.swap_req  = 1'b0;
    fb.frame_end = 1'b1;
    apply_stimulus();
    fb.frame_end = 1'b0;
    for (int i = 0; i < 700; i++) apply_stimulus();
    check_output("mid_clear_busy", fb.wr_ready, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_output("async_ready", fb.wr_ready, 1'b1);
    check_output("async_front", fb.front_sel, 1'b0);
    check_output("async_valid", fb.rd_valid, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();

    // The next swap behaves normally
    fb.wr_en = 1'b1; fb.wr_x = 6'd7; fb.wr_y = 6'd9; fb.wr_rgb = 3'b110;
    apply_stimulus();
    clear_inputs();
    do_swap();
    check_output("post_reset_front", fb.front_sel, 1'b1);
    read_pixel(7, 9);
    check_output("post_reset_rgb0", fb.rd_rgb0, 3'b110);
    for (int i = 0; i < 500; i++) begin
      random_write();
      random_read();
      apply_stimulus();
    end
    clear_inputs();
    apply_stimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
